// File: rtl/glitcher_pkg.sv
// Shared types and default field widths for the glitch sweep scheduler.
package glitcher_pkg;

    localparam int DELAY_W_DEF = 16;
    localparam int WIDTH_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_TGT,
        ST_SETTLE,
        ST_ARM,
        ST_WAIT,
        ST_REPORT,
        ST_STEP
    } sched_state_t;

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sweep_axis.sv
// One sweep axis: computes the next value of a start/end/step range and
// flags when the axis wraps back to its start value.
module sweep_axis #(
    parameter int W = 8
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    input  logic [W-1:0] step,
    output logic [W-1:0] next_val,
    output logic         wrap
);

    logic [W:0] sum;

    // Add at one extra bit so an overflow past the field width forces a wrap.
    always_comb begin
        sum      = {1'b0, cur} + {1'b0, step};
        wrap     = (step == '0) || sum[W] || (sum > {1'b0, hi});
        next_val = wrap ? lo : sum[W-1:0];
    end

endmodule

// File: rtl/glitch_sweep_sched.sv
// Glitch sweep scheduler: walks a (delay, width) grid, resetting the target,
// arming the pulse generator and reporting each attempt.
module glitch_sweep_sched
    import glitcher_pkg::*;
#(
    parameter int DELAY_W        = DELAY_W_DEF,
    parameter int WIDTH_W        = WIDTH_W_DEF,
    parameter int RST_CYCLES     = 1000,
    parameter int SETTLE_CYCLES  = 5000,
    parameter int TIMEOUT_CYCLES = 2**24 - 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [DELAY_W-1:0] dly_start_i,
    input  logic [DELAY_W-1:0] dly_end_i,
    input  logic [DELAY_W-1:0] dly_step_i,
    input  logic [WIDTH_W-1:0] wid_start_i,
    input  logic [WIDTH_W-1:0] wid_end_i,
    input  logic [WIDTH_W-1:0] wid_step_i,
    input  logic [7:0]         repeat_i,
    output logic               arm_o,
    output logic [DELAY_W-1:0] delay_o,
    output logic [WIDTH_W-1:0] width_o,
    input  logic               pulse_done_i,
    output logic               target_reset_o,
    output logic               rpt_valid_o,
    input  logic               rpt_ready_i,
    output logic               rpt_timeout_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int CNT_MAX = max3(RST_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    sched_state_t       state;
    sched_state_t       state_next;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_zero;
    logic               abort_hit;

    logic [DELAY_W-1:0] dly_first, dly_last, dly_step;
    logic [WIDTH_W-1:0] wid_first, wid_last, wid_step;
    logic [DELAY_W-1:0] delay_q;
    logic [WIDTH_W-1:0] width_q;
    logic [7:0]         rep_init;
    logic [7:0]         rep_left;
    logic               timeout_q;
    logic               done_q;

    logic [DELAY_W-1:0] dly_next;
    logic               dly_wrap;
    logic [WIDTH_W-1:0] wid_next;
    logic               wid_wrap;

    assign cnt_zero  = (cnt == '0);
    assign abort_hit = abort_i && (state != ST_IDLE);

    sweep_axis #(.W(DELAY_W)) u_delay_axis (
        .cur      (delay_q),
        .lo       (dly_first),
        .hi       (dly_last),
        .step     (dly_step),
        .next_val (dly_next),
        .wrap     (dly_wrap)
    );

    sweep_axis #(.W(WIDTH_W)) u_width_axis (
        .cur      (width_q),
        .lo       (wid_first),
        .hi       (wid_last),
        .step     (wid_step),
        .next_val (wid_next),
        .wrap     (wid_wrap)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic and state-decoded outputs; abort overrides everything.
    always_comb begin
        state_next     = state;
        arm_o          = 1'b0;
        target_reset_o = 1'b0;
        rpt_valid_o    = 1'b0;
        busy_o         = (state != ST_IDLE);
        if (abort_hit) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (start_i) state_next = ST_RST_TGT;
                ST_RST_TGT: if (cnt_zero) state_next = ST_SETTLE;
                ST_SETTLE:  if (cnt_zero) state_next = ST_ARM;
                ST_ARM:     state_next = ST_WAIT;
                ST_WAIT:    if (pulse_done_i || cnt_zero) state_next = ST_REPORT;
                ST_REPORT:  if (rpt_ready_i) state_next = ST_STEP;
                ST_STEP: begin
                    if (rep_left == '0 && wid_wrap && dly_wrap) state_next = ST_IDLE;
                    else                                          state_next = ST_RST_TGT;
                end
                default:    state_next = ST_IDLE;
            endcase
        end
        case (state)
            ST_RST_TGT: target_reset_o = 1'b1;
            ST_ARM:     arm_o          = 1'b1;
            ST_REPORT:  rpt_valid_o    = 1'b1;
            default:    ;
        endcase
    end

    // Shared down-counter: loaded with the duration of the state being
    // entered, otherwise counts down and holds at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state_next != state) begin
            case (state_next)
                ST_RST_TGT: cnt <= CNT_W'(RST_CYCLES - 1);
                ST_SETTLE:  cnt <= CNT_W'(SETTLE_CYCLES - 1);
                ST_WAIT:    cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
                default:    cnt <= '0;
            endcase
        end else if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Sweep datapath: range latch, point/repeat advance, timeout flag, done strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_first <= '0;
            dly_last  <= '0;
            dly_step  <= '0;
            wid_first <= '0;
            wid_last  <= '0;
            wid_step  <= '0;
            delay_q   <= '0;
            width_q   <= '0;
            rep_init  <= '0;
            rep_left  <= '0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!abort_hit) begin
                case (state)
                    ST_IDLE: begin
                        if (start_i) begin
                            dly_first <= dly_start_i;
                            dly_last  <= dly_end_i;
                            dly_step  <= dly_step_i;
                            wid_first <= wid_start_i;
                            wid_last  <= wid_end_i;
                            wid_step  <= wid_step_i;
                            delay_q   <= dly_start_i;
                            width_q   <= wid_start_i;
                            rep_init  <= (repeat_i == '0) ? '0 : repeat_i - 8'd1;
                            rep_left  <= (repeat_i == '0) ? '0 : repeat_i - 8'd1;
                            timeout_q <= 1'b0;
                        end
                    end
                    ST_ARM:  timeout_q <= 1'b0;
                    ST_WAIT: begin
                        if (!pulse_done_i && cnt_zero) timeout_q <= 1'b1;
                    end
                    ST_STEP: begin
                        if (rep_left != '0) begin
                            rep_left <= rep_left - 8'd1;
                        end else begin
                            rep_left <= rep_init;
                            if (wid_wrap) begin
                                width_q <= wid_first;
                                if (dly_wrap) done_q  <= 1'b1;
                                else          delay_q <= dly_next;
                            end else begin
                                width_q <= wid_next;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign delay_o       = delay_q;
    assign width_o       = width_q;
    assign rpt_timeout_o = timeout_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_glitch_sweep_sched.sv
// Directed bench for glitch_sweep_sched with small timing parameters.
module tb_glitch_sweep_sched;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        abort_i;
    logic [15:0] dly_start_i, dly_end_i, dly_step_i;
    logic [7:0]  wid_start_i, wid_end_i, wid_step_i;
    logic [7:0]  repeat_i;
    logic        arm_o;
    logic [15:0] delay_o;
    logic [7:0]  width_o;
    logic        pulse_done_i;
    logic        target_reset_o;
    logic        rpt_valid_o;
    logic        rpt_ready_i;
    logic        rpt_timeout_o;
    logic        busy_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;
    int arm_cnt = 0;
    int done_cnt = 0;
    int a0, d0;

    glitch_sweep_sched #(
        .DELAY_W        (16),
        .WIDTH_W        (8),
        .RST_CYCLES     (4),
        .SETTLE_CYCLES  (3),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .dly_start_i    (dly_start_i),
        .dly_end_i      (dly_end_i),
        .dly_step_i     (dly_step_i),
        .wid_start_i    (wid_start_i),
        .wid_end_i      (wid_end_i),
        .wid_step_i     (wid_step_i),
        .repeat_i       (repeat_i),
        .arm_o          (arm_o),
        .delay_o        (delay_o),
        .width_o        (width_o),
        .pulse_done_i   (pulse_done_i),
        .target_reset_o (target_reset_o),
        .rpt_valid_o    (rpt_valid_o),
        .rpt_ready_i    (rpt_ready_i),
        .rpt_timeout_o  (rpt_timeout_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count arm and done strobes as seen mid-cycle.
    always @(negedge clk) begin
        if (arm_o)  arm_cnt  <= arm_cnt + 1;
        if (done_o) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic setup(input int d0_, input int d1_, input int ds_,
                         input int w0_, input int w1_, input int ws_, input int rep_);
        dly_start_i = 16'(d0_);
        dly_end_i   = 16'(d1_);
        dly_step_i  = 16'(ds_);
        wid_start_i = 8'(w0_);
        wid_end_i   = 8'(w1_);
        wid_step_i  = 8'(ws_);
        repeat_i    = 8'(rep_);
    endtask

    task automatic kick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_arm(input string tag);
        for (int k = 0; k < 60 && !arm_o; k++) tick();
        check({tag, " arm seen"}, arm_o, 1);
    endtask

    task automatic run_point(input string tag, input int d, input int w);
        wait_arm(tag);
        check({tag, " delay"}, delay_o, d);
        check({tag, " width"}, width_o, w);
        tick();
        tick();
        pulse_done_i = 1'b1;
        tick();
        pulse_done_i = 1'b0;
        check({tag, " rpt_valid"}, rpt_valid_o, 1);
        check({tag, " rpt_timeout"}, rpt_timeout_o, 0);
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 60 && !done_o; k++) tick();
        check({tag, " done seen"}, done_o, 1);
        tick();
        check({tag, " idle after done"}, busy_o, 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        start_i      = 1'b0;
        abort_i      = 1'b0;
        pulse_done_i = 1'b0;
        rpt_ready_i  = 1'b1;
        setup(0, 0, 0, 0, 0, 0, 0);

        // Reset state
        tick();
        tick();
        check("rst arm", arm_o, 0);
        check("rst target_reset", target_reset_o, 0);
        check("rst rpt_valid", rpt_valid_o, 0);
        check("rst rpt_timeout", rpt_timeout_o, 0);
        check("rst busy", busy_o, 0);
        check("rst done", done_o, 0);
        check("rst delay", delay_o, 0);
        check("rst width", width_o, 0);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check("no autostart", busy_o, 0);

        // Full 3x2 sweep with start-to-arm timing
        setup(10, 12, 1, 5, 6, 1, 1);
        a0 = arm_cnt;
        d0 = done_cnt;
        kick();
        check("N+1 target_reset", target_reset_o, 1);
        check("N+1 busy", busy_o, 1);
        check("N+1 delay", delay_o, 10);
        check("N+1 width", width_o, 5);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("N+2..4 target_reset", target_reset_o, 1);
        end
        tick();
        check("N+5 target_reset", target_reset_o, 0);
        tick();
        tick();
        check("N+7 arm", arm_o, 0);
        tick();
        check("N+8 arm", arm_o, 1);
        run_point("p0", 10, 5);
        run_point("p1", 10, 6);
        run_point("p2", 11, 5);
        run_point("p3", 11, 6);
        run_point("p4", 12, 5);
        run_point("p5", 12, 6);
        wait_done("sweep");
        tick();
        check("sweep arm count", arm_cnt - a0, 6);
        check("sweep done count", done_cnt - d0, 1);

        // Timeout with report held by backpressure
        setup(7, 7, 1, 3, 3, 1, 1);
        rpt_ready_i = 1'b0;
        kick();
        wait_arm("to");
        for (int i = 0; i < 20; i++) tick();
        check("to last wait valid", rpt_valid_o, 0);
        tick();
        check("to valid", rpt_valid_o, 1);
        check("to timeout", rpt_timeout_o, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to hold valid", rpt_valid_o, 1);
            check("to hold timeout", rpt_timeout_o, 1);
            check("to hold delay", delay_o, 7);
            check("to hold width", width_o, 3);
        end
        rpt_ready_i = 1'b1;
        wait_done("to");

        // pulse_done on the expiry cycle wins over the timeout
        kick();
        wait_arm("tie");
        for (int i = 0; i < 20; i++) tick();
        check("tie pre valid", rpt_valid_o, 0);
        pulse_done_i = 1'b1;
        tick();
        pulse_done_i = 1'b0;
        check("tie valid", rpt_valid_o, 1);
        check("tie timeout", rpt_timeout_o, 0);
        wait_done("tie");

        // Width carry-free overflow past end, zero delay step
        setup(100, 200, 0, 250, 255, 4, 1);
        a0 = arm_cnt;
        d0 = done_cnt;
        kick();
        run_point("w0", 100, 250);
        run_point("w1", 100, 254);
        wait_done("wrap");
        tick();
        check("wrap arm count", arm_cnt - a0, 2);
        check("wrap done count", done_cnt - d0, 1);

        // Abort during WAIT with report not accepted
        setup(1, 3, 1, 1, 2, 1, 1);
        kick();
        run_point("ab0", 1, 1);
        wait_arm("ab1");
        check("ab1 width", width_o, 2);
        tick();
        rpt_ready_i = 1'b0;
        abort_i = 1'b1;
        d0 = done_cnt;
        tick();
        abort_i = 1'b0;
        check("abort busy", busy_o, 0);
        check("abort rpt_valid", rpt_valid_o, 0);
        check("abort target_reset", target_reset_o, 0);
        check("abort arm", arm_o, 0);
        for (int i = 0; i < 10; i++) tick();
        check("abort no done", done_cnt - d0, 0);
        check("abort stays idle", busy_o, 0);
        rpt_ready_i = 1'b1;
        kick();
        check("restart delay", delay_o, 1);
        check("restart width", width_o, 1);
        wait_arm("restart");
        check("restart arm delay", delay_o, 1);
        check("restart arm width", width_o, 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort2 busy", busy_o, 0);

        // Repeats on a single point; start mid-sweep must be ignored
        setup(9, 9, 1, 4, 4, 1, 3);
        a0 = arm_cnt;
        kick();
        run_point("r1", 9, 4);
        dly_start_i = 16'd99;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        run_point("r2", 9, 4);
        run_point("r3", 9, 4);
        wait_done("rep3");
        tick();
        check("rep3 arm count", arm_cnt - a0, 3);

        setup(9, 9, 1, 4, 4, 1, 0);
        a0 = arm_cnt;
        kick();
        run_point("r0", 9, 4);
        wait_done("rep0");
        tick();
        check("rep0 arm count", arm_cnt - a0, 1);

        // Asynchronous reset mid-sweep
        setup(20, 21, 1, 8, 8, 1, 1);
        kick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy", busy_o, 0);
        check("async rst target_reset", target_reset_o, 0);
        check("async rst delay", delay_o, 0);
        check("async rst width", width_o, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("after async rst idle", busy_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
